global_broadcast_unit: RTL and testbench
========================================

# global_broadcast_unit

Expands one 8-bit per-channel scalar into a full IMG_W x IMG_H feature map by repeating it for every pixel position. It is the inverse direction of the global average pooling stage: the pooling stage reduces a 196-pixel map to one value, and this block regenerates the map, for example for channel-attention rescaling or unpooling. Scalars enter on a valid/ready interface into a small FIFO. Pixels leave in raster order on a valid/ready stream with position and frame markers.

## Interface
- IMG_W, 14, pixels per row; legal range 1..256
- IMG_H, 14, rows per map; legal range 1..256
- FIFO_DEPTH, 4, scalar FIFO entries; must be a power of two and at least 2
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  8  scalar to broadcast, unsigned
- in_valid  input  1  in_data is presented
- in_ready  output  1  FIFO can accept; equals !full, registered-state driven, with no combinational path from out_ready
- out_data  output  8  broadcast pixel value
- out_valid  output  1  output beat is presented
- out_ready  input  1  downstream accepts the beat
- out_row  output  8  row index of the current beat, 0..IMG_H-1
- out_col  output  8  column index of the current beat, 0..IMG_W-1
- out_first  output  1  high on the beat at position (0,0)
- out_last  output  1  high on the beat at position (IMG_H-1, IMG_W-1)
- busy  output  1  high when the FIFO is non-empty or the state is EMIT

## Operation
- **Push:** a scalar is written to the FIFO when in_valid && in_ready.
- **Pop:** pops move the FIFO head into a hold register. out_data always equals the hold register.
- **States:**
  - IDLE: out_valid=0. When the FIFO is non-empty, pop, clear row/col, go to EMIT.
  - EMIT: out_valid=1. On out_valid && out_ready, advance the position: col++; when col = IMG_W-1, wrap col to 0 and increment row.
  - Last beat accepted, FIFO non-empty: pop in the same cycle, clear row/col, stay in EMIT. There is no bubble between maps.
  - Last beat accepted, FIFO empty: go to IDLE, out_valid=0 next cycle.
- **Flags:** out_first and out_last are decoded from row/col and qualified by out_valid. For IMG_W=IMG_H=1 both are high on the single beat.
- **Full handling:** a push is ignored when the FIFO is full. in_ready is already low then, so an upstream that obeys the handshake never loses data.
- **Simultaneous push and pop:** count is unchanged; both pointers advance.
- **Buffering capacity:** up to FIFO_DEPTH scalars can wait in the FIFO plus one in the hold register.
- **Data:** values pass through unmodified; there is no arithmetic on data.
- **Reset values:**
  - out_data=0, out_valid=0, out_row=0, out_col=0, out_first=0, out_last=0, busy=0.
  - FIFO empty, state IDLE.
  - in_ready=1 from the moment rst_n deasserts.
- **Reset mid-frame:** the frame is abandoned and queued scalars are discarded. The next scalar accepted starts at (0,0).

## Timing
- **Latency:** a scalar accepted at edge E0 into an empty FIFO with the state IDLE is popped at E1. out_valid is high from E1 onward, giving 1-cycle latency from acceptance to first beat.
- **Throughput:** one beat per cycle while out_ready=1. A full map takes IMG_W*IMG_H cycles. Consecutive queued scalars stream contiguously.
- **Backpressure:** while out_valid && !out_ready, out_data, out_row, out_col, out_first and out_last hold stable. out_valid never drops without acceptance.
- **in_ready timing:** in_ready deasserts in the cycle after the FIFO becomes full. It reasserts in the cycle after a pop.
- **Outputs:** all outputs are registers or decodes of registers only.

## Test plan
- **Single map:** reset, push 0x5A, hold out_ready=1 -> 196 beats of 0x5A, in raster order (row 0..13, col 0..13). out_first is high on beat 0 only and out_last on beat 195 only. out_valid is low afterward and busy falls.
- **Back-to-back:** push 0x01, 0x02, 0x03, 0x04 on consecutive cycles, out_ready=1 -> 784 contiguous beats, each value for exactly 196 beats. No out_valid gap; out_first is high at beats 0, 196, 392 and 588.
- **Fill with out_ready=0:** hold in_valid high with values 0x10..0x15 -> 5 accepted (1 hold + 4 FIFO), then in_ready=0. Releasing out_ready emits 0x10..0x14 maps only.
- **Random backpressure:** toggle out_ready at 50% -> beat count is exactly 196 per scalar and outputs are stable while stalled.
- **Reset mid-frame:** assert rst_n=0 at beat 100 with 2 scalars queued -> all outputs reach their reset values asynchronously. After release, push 0xC3 -> a fresh map of 0xC3 starting at (0,0).
- **Small geometry:** set IMG_W=2, IMG_H=3 and push 0xFF -> 6 beats at (0,0),(0,1),(1,0),(1,1),(2,0),(2,1), with out_last on the sixth beat.

Source files
------------

// File: rtl/global_broadcast_unit.sv
// Broadcasts each queued 8-bit scalar over an IMG_W x IMG_H raster stream.
// Scalars are buffered in a small FIFO; one map is emitted per scalar.
module global_broadcast_unit #(
    parameter int unsigned IMG_W      = 14,
    parameter int unsigned IMG_H      = 14,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_row,
    output logic [7:0] out_col,
    output logic       out_first,
    output logic       out_last,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]    COL_MAX  = 8'(IMG_W - 1);
    localparam logic [7:0]    ROW_MAX  = 8'(IMG_H - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      row_q, row_d, col_q, col_d;
    logic            in_ready_q, out_valid_q, first_q, last_q, busy_q;
    logic            push, pop;
    logic            fifo_nonempty;

    assign push          = in_valid && in_ready_q;
    assign fifo_nonempty = (count_q != '0);

    // Position sequencing and pop decisions
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (row_q == ROW_MAX && col_q == COL_MAX) begin
                        row_d = '0;
                        col_d = '0;
                        if (fifo_nonempty) pop = 1'b1;
                        else               state_d = IDLE;
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + 8'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
        endcase
    end

    assign hold_d  = pop ? mem[rd_ptr_q] : hold_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    // FIFO storage carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            hold_q      <= hold_d;
            row_q       <= row_d;
            col_q       <= col_d;
            in_ready_q  <= (count_d != FULL_CNT);
            out_valid_q <= (state_d == EMIT);
            first_q     <= (state_d == EMIT) && (row_d == '0) && (col_d == '0);
            last_q      <= (state_d == EMIT) && (row_d == ROW_MAX) && (col_d == COL_MAX);
            busy_q      <= (count_d != '0) || (state_d == EMIT);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = hold_q;
    assign out_valid = out_valid_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_global_broadcast_unit.sv
// Directed bench for global_broadcast_unit: 14x14 instance plus a 2x3 instance
// for the small-geometry case.
module tb_global_broadcast_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data, out_row, out_col;
    logic       out_valid, out_ready, out_first, out_last, busy;

    logic [7:0] s_in_data;
    logic       s_in_valid, s_in_ready;
    logic [7:0] s_out_data, s_out_row, s_out_col;
    logic       s_out_valid, s_out_ready, s_out_first, s_out_last, s_busy;

    int vectors     = 0;
    int miscompares = 0;

    global_broadcast_unit #(.IMG_W(14), .IMG_H(14), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col),
        .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    global_broadcast_unit #(.IMG_W(2), .IMG_H(3), .FIFO_DEPTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_row(s_out_row), .out_col(s_out_col),
        .out_first(s_out_first), .out_last(s_out_last), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data,  0);
        check({tag, "_row"},   out_row,   0);
        check({tag, "_col"},   out_col,   0);
        check({tag, "_first"}, out_first, 0);
        check({tag, "_last"},  out_last,  0);
        check({tag, "_busy"},  busy,      0);
    endtask

    // Consume nmaps 14x14 maps carrying values v0, v0+1, ...
    task automatic expect_stream(input logic [7:0] v0, input int nmaps,
                                 input bit rnd, input bit contig);
        int k = 0;
        int cyc = 0;
        int total = nmaps * 196;
        int m, p;
        bit started = 1'b0;
        bit pv = 1'b0, pr = 1'b0;
        logic [7:0] pd = '0, prow = '0, pcol = '0;
        logic pf = 1'b0, pl = 1'b0;
        while (k < total && cyc < 20000) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                check("stall_valid", out_valid, 1);
                check("stall_data",  out_data,  pd);
                check("stall_row",   out_row,   prow);
                check("stall_col",   out_col,   pcol);
                check("stall_first", out_first, pf);
                check("stall_last",  out_last,  pl);
            end
            if (contig && started) check("contig_valid", out_valid, 1);
            if (out_valid && out_ready) begin
                m = k / 196;
                p = k % 196;
                check("beat_data",  out_data,  8'(v0 + 8'(m)));
                check("beat_row",   out_row,   p / 14);
                check("beat_col",   out_col,   p % 14);
                check("beat_first", out_first, (p == 0) ? 1 : 0);
                check("beat_last",  out_last,  (p == 195) ? 1 : 0);
                started = 1'b1;
                k++;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            prow = out_row; pcol = out_col; pf = out_first; pl = out_last;
            @(negedge clk);
            cyc++;
        end
        check("beat_count", k, total);
        check("end_valid", out_valid, 0);
        check("end_busy",  busy,      0);
    endtask

    initial begin
        int k, cyc;
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;

        // Reset state
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        check("idle_valid", out_valid, 0);

        // Single map
        out_ready = 1'b1;
        push(8'h5A);
        check("lat_e0_valid", out_valid, 0);
        check("lat_e0_busy",  busy,      1);
        expect_stream(8'h5A, 1, 1'b0, 1'b1);

        // Back-to-back with pushes overlapping emission
        fork
            begin
                push(8'h01); push(8'h02); push(8'h03); push(8'h04);
            end
            expect_stream(8'h01, 4, 1'b0, 1'b1);
        join

        // Fill with out_ready low: 1 hold + 4 FIFO entries
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("fill_in_ready", in_ready, (i < 5) ? 1 : 0);
            in_data  = 8'(8'h10 + i);
            in_valid = 1'b1;
            @(negedge clk);
        end
        check("full_in_ready", in_ready, 0);
        in_valid = 1'b0;
        check("full_data",  out_data,  8'h10);
        check("full_first", out_first, 1);
        check("full_busy",  busy,      1);
        out_ready = 1'b1;
        expect_stream(8'h10, 5, 1'b0, 1'b1);

        // Random backpressure
        push(8'h77);
        push(8'h78);
        expect_stream(8'h77, 2, 1'b1, 1'b0);
        out_ready = 1'b1;

        // Reset mid-frame with two scalars queued
        out_ready = 1'b0;
        push(8'hA0); push(8'hA1); push(8'hA2);
        out_ready = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        check("midrst_idle", out_valid, 0);
        push(8'hC3);
        expect_stream(8'hC3, 1, 1'b0, 1'b1);

        // Small geometry 2x3
        s_out_ready = 1'b1;
        s_in_data   = 8'hFF;
        s_in_valid  = 1'b1;
        @(negedge clk);
        s_in_valid  = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 20) begin
            if (s_out_valid && s_out_ready) begin
                check("small_data",  s_out_data,  8'hFF);
                check("small_row",   s_out_row,   k / 2);
                check("small_col",   s_out_col,   k % 2);
                check("small_first", s_out_first, (k == 0) ? 1 : 0);
                check("small_last",  s_out_last,  (k == 5) ? 1 : 0);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        check("small_count", k, 6);
        check("small_end_valid", s_out_valid, 0);
        check("small_end_busy",  s_busy,      0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
